// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the load/store path. Data accesses win arbitration unless fetch has been
// passed over STARVE_LIMIT times in a row. Each access is a req/ack handshake
// that is aborted with an error pulse if no ack arrives within TIMEOUT cycles.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy
);

   localparam int              SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [15:0]     TMO_TERM   = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_ACC = 2'd1,
      D_ACC  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           mem_req_q, mem_req_d;
   logic           mem_we_q, mem_we_d;
   logic [31:0]    mem_addr_q, mem_addr_d;
   logic [31:0]    mem_wdata_q, mem_wdata_d;
   logic [3:0]     mem_wstrb_q, mem_wstrb_d;
   logic [31:0]    if_rdata_q, if_rdata_d;
   logic [31:0]    d_rdata_q, d_rdata_d;
   logic           if_valid_q, if_valid_d;
   logic           d_done_q, d_done_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic [SW-1:0]  starve_q, starve_d;
   logic [15:0]    tmo_q, tmo_d;
   logic [15:0]    tmo_next_s;
   logic           d_req_s;

   assign d_req_s    = d_read | d_write;
   assign tmo_next_s = tmo_q + 16'd1;

   // Arbitration, memory handshake tracking, timeout and completion pulses.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_valid_d  = 1'b0;
      d_done_d    = 1'b0;
      err_d       = 1'b0;
      starve_d    = starve_q;
      tmo_d       = tmo_q;

      case (state_q)
         IDLE: begin
            if (if_req && (starve_q == STARVE_MAX)) begin
               // Fetch has been passed over too often: force it through.
               state_d     = IF_ACC;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = 32'h0;
               mem_wstrb_d = 4'b0000;
               starve_d    = '0;
               tmo_d       = 16'd0;
            end else if (d_req_s) begin
               // Read+write together is handled as a store.
               state_d     = D_ACC;
               mem_req_d   = 1'b1;
               mem_we_d    = d_write;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_write ? d_wdata : 32'h0;
               mem_wstrb_d = d_write ? d_wstrb : 4'b0000;
               tmo_d       = 16'd0;
               if (if_req && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + SW'(1);
               end else begin
                  starve_d = starve_q;
               end
            end else if (if_req) begin
               state_d     = IF_ACC;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = 32'h0;
               mem_wstrb_d = 4'b0000;
               starve_d    = '0;
               tmo_d       = 16'd0;
            end else begin
               state_d = IDLE;
            end
         end

         IF_ACC, D_ACC: begin
            if (mem_ack || (tmo_next_s == TMO_TERM)) begin
               // An ack on the terminal-count cycle still completes normally.
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               err_d     = ~mem_ack;
               tmo_d     = mem_ack ? tmo_q : tmo_next_s;
               if (state_q == IF_ACC) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_ack ? mem_rdata : 32'h0;
               end else begin
                  d_done_d  = 1'b1;
                  d_rdata_d = mem_ack ? mem_rdata : 32'h0;
               end
            end else begin
               tmo_d = tmo_next_s;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'b0000;
         if_rdata_q  <= 32'h0;
         d_rdata_q   <= 32'h0;
         if_valid_q  <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         starve_q    <= '0;
         tmo_q       <= 16'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_valid_q  <= if_valid_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_done    = d_done_q;
   assign err       = err_q;
   assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between instruction fetch and the load/store path.
- The load/store path is driven by the decoder's mem_read/mem_write strobes.
- A small FSM grants one requester at a time, runs a req/ack transaction to memory, returns data with a one-cycle done pulse, and aborts transactions that never get an ack.
- Data accesses have priority; a starvation guard bounds how long fetch can wait.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while if_req is pending before fetch is forced (≥1)
TIMEOUT, 255, cycles to wait for mem_ack before abort (≥1, fits 16 bits)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  32  fetch address
if_rdata  out  32  fetched word, valid with if_valid
if_valid  out  1  one-cycle fetch completion pulse
d_read  in  1  load request (decoder mem_read), level
d_write  in  1  store request (decoder mem_write), level
d_addr  in  32  data address
d_wdata  in  32  store data
d_wstrb  in  4  store byte enables
d_rdata  out  32  load data, valid with d_done
d_done  out  1  one-cycle data completion pulse
err  out  1  one-cycle pulse with if_valid/d_done when the access timed out
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte enables (0 on reads)
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_valid, d_done, err, busy = 0.
  - mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata = 0.
  - Starvation and timeout counters = 0.
- States: IDLE, IF_ACC, D_ACC. All outputs are registered.
- Arbitration happens only in IDLE, on the cycle a request is sampled:
  - Data requests (d_read | d_write) win.
  - Exception: if if_req is high and starve_cnt == STARVE_LIMIT, fetch wins.
- On grant:
  - Latch address, wdata and wstrb into the mem_* registers.
  - Set mem_req = 1 and mem_we = d_write the next cycle (request sampled in cycle N → mem_req high in N+1).
  - Clear the timeout counter.
- d_read and d_write both high: treated as a store (mem_we = 1, d_wstrb used). No error.
- Reads drive mem_wstrb = 0.
- Starvation counter:
  - Increments on each data grant made while if_req is high.
  - Resets to 0 on any fetch grant.
  - Saturates at STARVE_LIMIT.
  - Unchanged on a data grant while if_req is low.
- In IF_ACC / D_ACC, mem_req is held and mem_* are stable until mem_ack.
- mem_ack in cycle M (M may be N+1):
  - Cycle M+1: mem_req = 0; corresponding if_valid/d_done = 1; if_rdata/d_rdata = mem_rdata (d_rdata updated on stores too); state = IDLE.
  - Minimum request-to-done latency is 2 cycles.
- IDLE lasts at least one cycle between transactions. The next grant samples requests in the IDLE cycle M+1, where the requester still shows req (requesters drop req on seeing done). A back-to-back grant can therefore occur only in M+2.
- Timeout:
  - Counter increments each cycle in IF_ACC/D_ACC without mem_ack.
  - When it reaches TIMEOUT, the next cycle: mem_req = 0, the done/valid pulse fires with rdata = 0 and err = 1, state = IDLE.
  - mem_ack arriving on the same cycle as the timeout terminal count wins: normal completion, err = 0.
- Requester drops req mid-access: ignored. The access completes and its pulse still fires.
- mem_ack in IDLE: ignored, no pulse.
- Address/data inputs changing after grant: no effect (latched).
- Reset mid-access: immediate return to IDLE with all reset values, no completion pulse. Any later mem_ack for the abandoned access is ignored.
- if_valid and d_done are never high in the same cycle. At most one pulse per grant.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; memory acks 1 cycle after mem_req with 0x00500093 → mem_req in N+1, mem_we=0, if_valid=1 with if_rdata=0x00500093 in N+3; busy high N+1..N+2.
- Simultaneous: if_req and d_read (d_addr=0x2000, rdata 0xDEADBEEF) in the same IDLE cycle → data granted first, d_done with 0xDEADBEEF; fetch granted two cycles later.
- Starvation, STARVE_LIMIT=4: if_req held with d_read re-asserted continuously → exactly 4 data transactions, then a fetch grant, starve_cnt back to 0.
- Store: d_write=1, d_addr=0x3004, d_wdata=0x12345678, d_wstrb=4'b0011 → mem_we=1, mem_wstrb=0011, mem_wdata=0x12345678, d_done one cycle after ack; a second store with d_read=d_write=1 also issues mem_we=1.
- Timeout, TIMEOUT=8: d_read with mem_ack never asserted → mem_req high for 8 cycles, then d_done=1, err=1, d_rdata=0; a late mem_ack in IDLE produces no pulse.
- Reset mid-access: assert rst while in IF_ACC before ack → next cycle mem_req=0, busy=0, no if_valid; an ack arriving the cycle after reset is ignored.
